dmem_controller: RTL and testbench

DMEM_CONTROLLER -- requirements
Module: dmem_controller

---
 rtl/dmem_controller.sv | 170 +++++++++++++++++
 tb/tb_dmem_controller.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_controller.sv
// Data-memory controller: two requesters (CPU, debug) share one word-wide memory
// with round-robin arbitration, sub-word load extraction and read-modify-write stores.
module dmem_controller #(
  parameter int DEPTH_WORDS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  input  logic [2:0]  size0,
  input  logic [2:0]  size1,
  output logic        ack0,
  output logic        ack1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        err0,
  output logic        err1,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, DONE} state_t;

  state_t      state, next_state;
  logic        gnt, prio, we_l;
  logic [31:0] addr_l, wdata_l;
  logic [2:0]  size_l;
  logic [31:0] res_data, merged;
  logic        res_err;

  logic        any_req, grant_port;
  logic        bad_size, misaligned, out_of_range, fault;
  logic [31:0] word_idx;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_val, merge_val;

  // prio names the port that wins when both request; it flips away from each grantee
  always_comb begin
    any_req    = req0 | req1;
    grant_port = (req0 && req1) ? prio : (req1 && !req0);
  end

  always_comb begin
    case (size_l)
      3'b000, 3'b001, 3'b010: bad_size = 1'b0;
      3'b100, 3'b101:         bad_size = we_l;
      default:                bad_size = 1'b1;
    endcase
    misaligned   = ((size_l[1:0] == 2'b01) && addr_l[0]) ||
                   ((size_l[1:0] == 2'b10) && (addr_l[1:0] != 2'b00));
    word_idx     = {2'b00, addr_l[31:2]};
    out_of_range = word_idx >= 32'(DEPTH_WORDS);
    fault        = bad_size | misaligned | out_of_range;
  end

  always_comb begin
    case (addr_l[1:0])
      2'd0:    byte_sel = mem_rd[7:0];
      2'd1:    byte_sel = mem_rd[15:8];
      2'd2:    byte_sel = mem_rd[23:16];
      default: byte_sel = mem_rd[31:24];
    endcase
    half_sel = addr_l[1] ? mem_rd[31:16] : mem_rd[15:0];
    case (size_l[1:0])
      2'b00:   load_val = size_l[2] ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      2'b01:   load_val = size_l[2] ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_val = mem_rd;
    endcase
  end

  always_comb begin
    merge_val = mem_rd;
    if (size_l[1:0] == 2'b00) begin
      case (addr_l[1:0])
        2'd0:    merge_val[7:0]   = wdata_l[7:0];
        2'd1:    merge_val[15:8]  = wdata_l[7:0];
        2'd2:    merge_val[23:16] = wdata_l[7:0];
        default: merge_val[31:24] = wdata_l[7:0];
      endcase
    end else if (addr_l[1]) begin
      merge_val[31:16] = wdata_l[15:0];
    end else begin
      merge_val[15:0] = wdata_l[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (any_req) next_state = ACCESS;
      ACCESS:  begin
        if (fault || !we_l || (size_l[1:0] == 2'b10)) next_state = DONE;
        else                                          next_state = WRITE;
      end
      WRITE:   next_state = DONE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gnt      <= 1'b0;
      prio     <= 1'b0;
      we_l     <= 1'b0;
      addr_l   <= 32'h0;
      wdata_l  <= 32'h0;
      size_l   <= 3'b000;
      mem_a    <= 32'h0;
      res_data <= 32'h0;
      res_err  <= 1'b0;
      merged   <= 32'h0;
    end else begin
      case (state)
        IDLE: if (any_req) begin
          gnt      <= grant_port;
          prio     <= ~grant_port;
          we_l     <= grant_port ? we1    : we0;
          addr_l   <= grant_port ? addr1  : addr0;
          wdata_l  <= grant_port ? wdata1 : wdata0;
          size_l   <= grant_port ? size1  : size0;
          mem_a    <= grant_port ? {addr1[31:2], 2'b00} : {addr0[31:2], 2'b00};
          res_data <= 32'h0;
          res_err  <= 1'b0;
        end
        ACCESS: begin
          if (fault)      res_err  <= 1'b1;
          else if (!we_l) res_data <= load_val;
          merged <= merge_val;
        end
        default: ;
      endcase
    end
  end

  // Write strobes are gated by reset so an interrupted store never reaches memory
  always_comb begin
    ack0   = (state == DONE) && !gnt;
    ack1   = (state == DONE) && gnt;
    rdata0 = ack0 ? res_data : 32'h0;
    rdata1 = ack1 ? res_data : 32'h0;
    err0   = ack0 && res_err;
    err1   = ack1 && res_err;
    mem_we = 1'b0;
    mem_wd = 32'h0;
    if (!reset) begin
      if ((state == ACCESS) && we_l && !fault && (size_l[1:0] == 2'b10)) begin
        mem_we = 1'b1;
        mem_wd = wdata_l;
      end else if (state == WRITE) begin
        mem_we = 1'b1;
        mem_wd = merged;
      end
    end
  end

endmodule

// File: tb/tb_dmem_controller.sv
// Directed bench for dmem_controller: table of single accesses against a small
// memory model, plus arbitration and reset-during-store sequences.
module tb_dmem_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic [2:0]  size0, size1;
  logic        ack0, ack1, err0, err1;
  logic [31:0] rdata0, rdata1;
  logic        mem_we;
  logic [31:0] mem_a, mem_wd, mem_rd;

  logic [31:0] mem [0:31];
  logic        mem_init;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  dmem_controller #(.DEPTH_WORDS(32)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .size0(size0), .size1(size1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .err0(err0), .err1(err1),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  // Memory model: combinational read, write on rising edge, preload while mem_init
  always_comb mem_rd = mem[mem_a[6:2]];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'h0;
      mem[0] <= 32'h1122_3344;
      mem[1] <= 32'h5566_7788;
      mem[3] <= 32'h8081_8283;
    end else if (mem_we) begin
      mem[mem_a[6:2]] <= mem_wd;
    end
  end

  typedef struct {
    string       name;
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  size;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_writes;
    logic [31:0] exp_wd;
  } vec_t;

  vec_t vecs [18];

  function automatic vec_t mk(string name, logic port, logic we, logic [31:0] addr,
                              logic [31:0] wdata, logic [2:0] size, logic [31:0] exp_rdata,
                              logic exp_err, int exp_lat, int exp_writes, logic [31:0] exp_wd);
    vec_t v;
    v.name = name; v.port = port; v.we = we; v.addr = addr; v.wdata = wdata;
    v.size = size; v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat;
    v.exp_writes = exp_writes; v.exp_wd = exp_wd;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic idleInputs();
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0; size0 = 0; size1 = 0;
  endtask

  task automatic applyStimulus(input vec_t v);
    int          lat = 0;
    int          writes = 0;
    logic [31:0] got_wd = 32'h0;
    logic [31:0] got_rdata = 32'h0;
    logic        got_err = 1'b0;
    logic        wrong_ack = 1'b0;
    logic        stray_wd = 1'b0;
    @(negedge clk);
    idleInputs();
    if (v.port) begin
      req1 = 1; we1 = v.we; addr1 = v.addr; wdata1 = v.wdata; size1 = v.size;
    end else begin
      req0 = 1; we0 = v.we; addr0 = v.addr; wdata0 = v.wdata; size0 = v.size;
    end
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (mem_we) begin
        writes++;
        got_wd = mem_wd;
      end else if (mem_wd != 32'h0) begin
        stray_wd = 1'b1;
      end
      if (v.port ? ack0 : ack1) wrong_ack = 1'b1;
      if (v.port ? ack1 : ack0) begin
        lat = c;
        got_rdata = v.port ? rdata1 : rdata0;
        got_err   = v.port ? err1 : err0;
        break;
      end
    end
    idleInputs();
    checkOutput({v.name, " latency"}, lat, v.exp_lat);
    checkOutput({v.name, " rdata"}, got_rdata, v.exp_rdata);
    checkOutput({v.name, " err"}, {31'h0, got_err}, {31'h0, v.exp_err});
    checkOutput({v.name, " writes"}, writes, v.exp_writes);
    if (v.exp_writes > 0) checkOutput({v.name, " mem_wd"}, got_wd, v.exp_wd);
    checkOutput({v.name, " other_ack"}, {31'h0, wrong_ack}, 32'h0);
    checkOutput({v.name, " idle_wd"}, {31'h0, stray_wd}, 32'h0);
  endtask

  task automatic doReset();
    @(negedge clk);
    idleInputs();
    reset = 1;
    @(negedge clk);
    @(negedge clk);
    reset = 0;
  endtask

  initial begin
    int          order [4];
    logic [31:0] rd [4];
    int          n_ack;
    logic        prev_ack, adjacent, both;
    int          writes, acks;

    idleInputs();
    reset = 1;
    mem_init = 1;
    repeat (3) @(negedge clk);
    mem_init = 0;
    checkOutput("reset ack0", {31'h0, ack0}, 32'h0);
    checkOutput("reset ack1", {31'h0, ack1}, 32'h0);
    checkOutput("reset mem_we", {31'h0, mem_we}, 32'h0);
    checkOutput("reset mem_a", mem_a, 32'h0);
    checkOutput("reset mem_wd", mem_wd, 32'h0);
    checkOutput("reset rdata0", rdata0, 32'h0);
    checkOutput("reset err1", {31'h0, err1}, 32'h0);
    reset = 0;

    vecs[0]  = mk("LB 0x0D",      0, 0, 32'h0D, 32'h0,        3'b000, 32'hFFFF_FF82, 0, 2, 0, 32'h0);
    vecs[1]  = mk("LHU 0x0E",     0, 0, 32'h0E, 32'h0,        3'b101, 32'h0000_8081, 0, 2, 0, 32'h0);
    vecs[2]  = mk("LH 0x0E",      0, 0, 32'h0E, 32'h0,        3'b001, 32'hFFFF_8081, 0, 2, 0, 32'h0);
    vecs[3]  = mk("LBU 0x0C",     0, 0, 32'h0C, 32'h0,        3'b100, 32'h0000_0083, 0, 2, 0, 32'h0);
    vecs[4]  = mk("LW 0x00",      0, 0, 32'h00, 32'h0,        3'b010, 32'h1122_3344, 0, 2, 0, 32'h0);
    vecs[5]  = mk("p1 LB 0x03",   1, 0, 32'h03, 32'h0,        3'b000, 32'h0000_0011, 0, 2, 0, 32'h0);
    vecs[6]  = mk("p1 SB 0x0C",   1, 1, 32'h0C, 32'h0000_00AA, 3'b000, 32'h0,        0, 3, 1, 32'h8081_82AA);
    vecs[7]  = mk("LW 0x0C",      0, 0, 32'h0C, 32'h0,        3'b010, 32'h8081_82AA, 0, 2, 0, 32'h0);
    vecs[8]  = mk("SH 0x06",      0, 1, 32'h06, 32'h0000_BEEF, 3'b001, 32'h0,        0, 3, 1, 32'hBEEF_7788);
    vecs[9]  = mk("SW 0x08",      0, 1, 32'h08, 32'hDEAD_BEEF, 3'b010, 32'h0,        0, 2, 1, 32'hDEAD_BEEF);
    vecs[10] = mk("p1 LW 0x04",   1, 0, 32'h04, 32'h0,        3'b010, 32'hBEEF_7788, 0, 2, 0, 32'h0);
    vecs[11] = mk("LW 0x08",      0, 0, 32'h08, 32'h0,        3'b010, 32'hDEAD_BEEF, 0, 2, 0, 32'h0);
    vecs[12] = mk("fault LW 0x02", 0, 0, 32'h02, 32'h0,       3'b010, 32'h0,        1, 2, 0, 32'h0);
    vecs[13] = mk("fault LH 0x03", 0, 0, 32'h03, 32'h0,       3'b001, 32'h0,        1, 2, 0, 32'h0);
    vecs[14] = mk("fault SW 0x80", 0, 1, 32'h80, 32'h1234_5678, 3'b010, 32'h0,      1, 2, 0, 32'h0);
    vecs[15] = mk("fault size011", 1, 0, 32'h00, 32'h0,       3'b011, 32'h0,        1, 2, 0, 32'h0);
    vecs[16] = mk("fault st 100",  0, 1, 32'h00, 32'h0000_0055, 3'b100, 32'h0,      1, 2, 0, 32'h0);
    vecs[17] = mk("fault LB 0x80", 0, 0, 32'h80, 32'h0,       3'b000, 32'h0,        1, 2, 0, 32'h0);

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Both ports request continuously: acks must alternate starting with port 0
    doReset();
    req0 = 1; we0 = 0; addr0 = 32'h00; size0 = 3'b010;
    req1 = 1; we1 = 0; addr1 = 32'h04; size1 = 3'b010;
    n_ack = 0; prev_ack = 0; adjacent = 0; both = 0;
    for (int i = 0; i < 4; i++) begin
      order[i] = -1;
      rd[i] = 32'h0;
    end
    for (int c = 0; c < 30 && n_ack < 4; c++) begin
      @(negedge clk);
      if (ack0 && ack1) both = 1;
      if ((ack0 || ack1) && prev_ack) adjacent = 1;
      if (ack0 || ack1) begin
        order[n_ack] = ack1 ? 1 : 0;
        rd[n_ack] = ack1 ? rdata1 : rdata0;
        n_ack++;
      end
      prev_ack = ack0 || ack1;
    end
    idleInputs();
    checkOutput("rr ack count", n_ack, 4);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("rr order %0d", i), order[i], i % 2);
      checkOutput($sformatf("rr rdata %0d", i), rd[i], (i % 2) ? 32'hBEEF_7788 : 32'h1122_3344);
    end
    checkOutput("rr adjacent acks", {31'h0, adjacent}, 32'h0);
    checkOutput("rr double ack", {31'h0, both}, 32'h0);

    // Halfword store aborted by reset while in ACCESS
    doReset();
    req0 = 1; we0 = 1; addr0 = 32'h00; wdata0 = 32'h0000_1234; size0 = 3'b001;
    writes = 0; acks = 0;
    @(negedge clk);
    if (mem_we) writes++;
    reset = 1;
    idleInputs();
    @(negedge clk);
    if (mem_we) writes++;
    if (ack0 || ack1) acks++;
    reset = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (mem_we) writes++;
      if (ack0 || ack1) acks++;
    end
    checkOutput("abort writes", writes, 0);
    checkOutput("abort acks", acks, 0);
    checkOutput("abort word0", mem[0], 32'h1122_3344);
    checkOutput("abort mem_a", mem_a, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
